// File: rtl/lsu_access_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 width codes, FSM states, byte strobes.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package lsu_access_unit_pkg;

  localparam int XLEN = 32;

  // RISC-V load/store width codes carried in funct3
  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_width_e;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MEM  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Byte-lane strobe patterns before shifting to the addressed lane
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // Illegal width code for the direction, or natural alignment violated
  function automatic logic lsu_is_fault(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      LSU_B:  illegal = 1'b0;
      LSU_H:  misaligned = addr_lo[0];
      LSU_W:  misaligned = (addr_lo != 2'b00);
      LSU_BU: illegal = we;
      LSU_HU: begin
        illegal    = we;
        misaligned = addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_access_unit_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
  import lsu_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata_word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to the width code
  always_comb begin
    byte_sel  = rdata_word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    load_data = rdata_word;
    case (funct3)
      LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
      LSU_BU:  load_data = {24'h000000, byte_sel};
      LSU_HU:  load_data = {16'h0000, half_sel};
      default: load_data = rdata_word;
    endcase
  end

endmodule

// File: rtl/lsu_access_unit.sv
// Load/store unit: one data-memory access per request with lane alignment and fault detection.
// Latency: accept N -> mem_req N+1, ack M -> resp_valid M+1; faults respond at N+1.
// Backpressure: req_ready low (busy high) from accept until the response cycle has passed.
module lsu_access_unit
  import lsu_access_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_fault,
  output logic            busy
);

  logic [1:0]      state_q,      state_d;
  logic            mem_we_q,     mem_we_d;
  logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
  logic [3:0]      mem_wstrb_q,  mem_wstrb_d;
  logic [XLEN-1:0] mem_wdata_q,  mem_wdata_d;
  logic [2:0]      funct3_q,     funct3_d;
  logic [1:0]      addr_lo_q,    addr_lo_d;
  logic [4:0]      rd_q,         rd_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]      resp_rd_q,    resp_rd_d;
  logic            resp_fault_q, resp_fault_d;

  logic            req_fault;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] load_data;

  // Extraction works on the latched width/offset so mem_rdata only reaches a flop
  lsu_load_align u_load_align (
    .rdata_word (mem_rdata),
    .addr_lo    (addr_lo_q),
    .funct3     (funct3_q),
    .load_data  (load_data)
  );

  // Store lane formatting: replicate the datum across lanes, strobe the addressed ones
  always_comb begin
    req_fault = lsu_is_fault(req_we, req_funct3, req_addr[1:0]);
    st_strb   = STRB_W;
    st_wdata  = req_wdata;
    case (req_funct3)
      LSU_B: begin
        st_strb  = STRB_B << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      LSU_H: begin
        st_strb  = STRB_H << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_strb  = STRB_W;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Next-state and datapath capture for the IDLE/MEM/RESP sequence
  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    rd_d         = rd_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            // No memory access: answer directly with a fault
            state_d      = ST_RESP;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
            resp_rd_d    = '0;
          end else begin
            state_d      = ST_MEM;
            resp_fault_d = 1'b0;
            mem_we_d     = req_we;
            mem_addr_d   = {req_addr[XLEN-1:2], 2'b00};
            mem_wstrb_d  = req_we ? st_strb : STRB_NONE;
            mem_wdata_d  = req_we ? st_wdata : '0;
            funct3_d     = req_funct3;
            addr_lo_d    = req_addr[1:0];
            rd_d         = req_rd;
          end
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d      = ST_RESP;
          resp_rdata_d = mem_we_q ? '0 : load_data;
          resp_rd_d    = mem_we_q ? 5'd0 : rd_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= STRB_NONE;
      mem_wdata_q  <= '0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      rd_q         <= 5'd0;
      resp_rdata_q <= '0;
      resp_rd_q    <= 5'd0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      rd_q         <= rd_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Handshake outputs decode straight from state
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = ~req_ready;
  assign mem_req    = (state_q == ST_MEM);
  assign resp_valid = (state_q == ST_RESP);

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_fault = resp_fault_q;

endmodule
